// File: rtl/qbus_dma_arbiter_pkg.sv
// Shared types and defaults for the Q-bus DMA arbiter.
package qbus_dma_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    PASS     = 3'd2,
    WAIT_BUS = 3'd3,
    GRANT    = 3'd4,
    RELEASE  = 3'd5
  } arb_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_GRANT_TIMEOUT = 64;
  localparam int DEF_MAX_HOLD      = 256;

  // Index width for a requester count; a single requester still gets one bit
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the larger of the two cycle limits
  function automatic int count_width(input int a, input int b);
    return (a > b) ? $clog2(a + 1) : $clog2(b + 1);
  endfunction

endpackage

// File: rtl/qbus_dma_arbiter_if.sv
// Q-bus DMA handshake signals between the arbiter and the CPU/bus side.
interface qbus_dma_arbiter_if;
  logic dmr_n;
  logic dmgi_n;
  logic dmgo_n;
  logic sack_n;
  logic sync_n;
  logic rply_n;

  modport arb (
    output dmr_n,
    output dmgo_n,
    output sack_n,
    input  dmgi_n,
    input  sync_n,
    input  rply_n
  );

  modport cpu (
    input  dmr_n,
    input  dmgo_n,
    input  sack_n,
    output dmgi_n,
    output sync_n,
    output rply_n
  );
endinterface

// File: rtl/qbus_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module qbus_dma_arbiter_rr_pick #(
  parameter int N_REQ = 2,
  parameter int OW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [OW-1:0]    pick_idx,
  output logic             pick_valid
);

  logic [N_REQ-1:0] upper_s;
  logic [N_REQ-1:0] cand_s;

  // Keep only requests whose index is at or above the pointer
  always_comb begin
    upper_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (i >= int'(ptr)) begin
        upper_s[i] = req[i];
      end else begin
        upper_s[i] = 1'b0;
      end
    end
  end

  // Lowest set bit, preferring the upper part so the search wraps around
  always_comb begin
    pick_valid = |req;
    pick_idx   = {OW{1'b0}};
    if (|upper_s) begin
      cand_s = upper_s;
    end else begin
      cand_s = req;
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_s[i]) begin
        pick_idx = OW'(i);
      end else begin
        pick_idx = pick_idx;
      end
    end
  end

  // One-hot form of the chosen index
  always_comb begin
    pick_oh = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      pick_oh[i] = pick_valid && (OW'(i) == pick_idx);
    end
  end

endmodule

// File: rtl/qbus_dma_arbiter.sv
// Q-bus DMA arbiter: requests the bus from the CPU with DMR/DMGI/SACK, waits
// for the bus to go idle and grants one local requester round-robin. Grants
// nobody here wants are passed down the DMGO daisy chain.
module qbus_dma_arbiter
  import qbus_dma_arbiter_pkg::*;
#(
  parameter int  N_REQ         = 2,
  parameter int  SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int  GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int  MAX_HOLD      = DEF_MAX_HOLD,
  localparam int OW            = owner_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     gnt,
  output logic [OW-1:0]        owner,
  output logic                 timeout_err,
  qbus_dma_arbiter_if.arb      bus
);

  localparam int CW = count_width(GRANT_TIMEOUT, MAX_HOLD);

  // Asynchronous bus inputs; idle level is 1 for all three
  logic [SYNC_STAGES-1:0] dmgi_sync_r;
  logic [SYNC_STAGES-1:0] sync_sync_r;
  logic [SYNC_STAGES-1:0] rply_sync_r;
  logic                   dmgi_s;
  logic                   sync_s;
  logic                   rply_s;

  arb_state_e       state_r;
  logic             dmr_n_r;
  logic             sack_n_r;
  logic             dmgo_n_r;
  logic [N_REQ-1:0] gnt_r;
  logic [OW-1:0]    owner_r;
  logic             timeout_err_r;
  logic [OW-1:0]    rr_ptr_r;
  logic [OW-1:0]    winner_r;
  logic [N_REQ-1:0] winner_oh_r;
  logic [CW-1:0]    cnt_r;

  logic [N_REQ-1:0] pick_oh_s;
  logic [OW-1:0]    pick_idx_s;
  logic             pick_valid_s;
  logic             req_expired_s;
  logic             hold_over_s;
  logic             owner_quit_s;
  logic             release_s;
  logic [OW-1:0]    next_ptr_s;

  // Shift each asynchronous bus input through its synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmgi_sync_r <= {SYNC_STAGES{1'b1}};
      sync_sync_r <= {SYNC_STAGES{1'b1}};
      rply_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      dmgi_sync_r[0] <= bus.dmgi_n;
      sync_sync_r[0] <= bus.sync_n;
      rply_sync_r[0] <= bus.rply_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dmgi_sync_r[i] <= dmgi_sync_r[i-1];
        sync_sync_r[i] <= sync_sync_r[i-1];
        rply_sync_r[i] <= rply_sync_r[i-1];
      end
    end
  end

  assign dmgi_s = dmgi_sync_r[SYNC_STAGES-1];
  assign sync_s = sync_sync_r[SYNC_STAGES-1];
  assign rply_s = rply_sync_r[SYNC_STAGES-1];

  qbus_dma_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_rr_pick (
    .req        (req),
    .ptr        (rr_ptr_r),
    .pick_oh    (pick_oh_s),
    .pick_idx   (pick_idx_s),
    .pick_valid (pick_valid_s)
  );

  // Limit detection, owner release conditions and the next round-robin start
  always_comb begin
    req_expired_s = (cnt_r == CW'(GRANT_TIMEOUT - 1));
    hold_over_s   = (cnt_r == CW'(MAX_HOLD - 1));
    owner_quit_s  = (|(done & winner_oh_r)) || !(|(req & winner_oh_r));
    release_s     = owner_quit_s || hold_over_s;
    if (winner_r == OW'(N_REQ - 1)) begin
      next_ptr_s = {OW{1'b0}};
    end else begin
      next_ptr_s = winner_r + OW'(1);
    end
  end

  // Arbitration sequencer with all bus-facing outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      dmr_n_r       <= 1'b1;
      sack_n_r      <= 1'b1;
      dmgo_n_r      <= 1'b1;
      gnt_r         <= {N_REQ{1'b0}};
      owner_r       <= {OW{1'b0}};
      timeout_err_r <= 1'b0;
      rr_ptr_r      <= {OW{1'b0}};
      winner_r      <= {OW{1'b0}};
      winner_oh_r   <= {N_REQ{1'b0}};
      cnt_r         <= {CW{1'b0}};
    end else begin
      timeout_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!dmgi_s) begin
            // Someone upstream already granted; it is not ours to take
            dmgo_n_r <= 1'b0;
            state_r  <= PASS;
          end else if (pick_valid_s) begin
            dmr_n_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= REQ;
          end
        end
        PASS: begin
          if (dmgi_s) begin
            dmgo_n_r <= 1'b1;
            state_r  <= IDLE;
          end else begin
            dmgo_n_r <= 1'b0;
          end
        end
        REQ: begin
          cnt_r <= cnt_r + CW'(1);
          // Grant is checked first so it wins over a coincident timeout
          if (!dmgi_s && pick_valid_s) begin
            sack_n_r    <= 1'b0;
            dmr_n_r     <= 1'b1;
            winner_r    <= pick_idx_s;
            winner_oh_r <= pick_oh_s;
            state_r     <= WAIT_BUS;
          end else if (!dmgi_s) begin
            dmr_n_r  <= 1'b1;
            dmgo_n_r <= 1'b0;
            state_r  <= PASS;
          end else if (req_expired_s) begin
            dmr_n_r       <= 1'b1;
            timeout_err_r <= 1'b1;
            state_r       <= IDLE;
          end
        end
        WAIT_BUS: begin
          // Previous master must have finished its cycle: SYNC and RPLY both high
          if (sync_s && rply_s) begin
            gnt_r   <= winner_oh_r;
            owner_r <= winner_r;
            cnt_r   <= {CW{1'b0}};
            state_r <= GRANT;
          end
        end
        GRANT: begin
          cnt_r <= cnt_r + CW'(1);
          if (release_s) begin
            gnt_r         <= {N_REQ{1'b0}};
            rr_ptr_r      <= next_ptr_s;
            timeout_err_r <= hold_over_s && !owner_quit_s;
            state_r       <= RELEASE;
          end
        end
        RELEASE: begin
          sack_n_r <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          dmr_n_r  <= 1'b1;
          sack_n_r <= 1'b1;
          dmgo_n_r <= 1'b1;
          gnt_r    <= {N_REQ{1'b0}};
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.dmr_n  = dmr_n_r;
  assign bus.sack_n = sack_n_r;
  assign bus.dmgo_n = dmgo_n_r;
  assign gnt        = gnt_r;
  assign owner      = owner_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Self-checking bench for qbus_dma_arbiter against a transaction-level model.
module tb_qbus_dma_arbiter;

  localparam int N   = 2;
  localparam int S   = 2;
  localparam int GTO = 64;
  localparam int MH  = 256;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [0:0]   owner;
  logic         timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int rr_ptr_m = 0;

  qbus_dma_arbiter_if bus_if ();

  qbus_dma_arbiter #(
    .N_REQ         (N),
    .SYNC_STAGES   (S),
    .GRANT_TIMEOUT (GTO),
    .MAX_HOLD      (MH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .owner       (owner),
    .timeout_err (timeout_err),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Winner: first requester at or after the pointer, searching modulo N
  function automatic int model_winner(input logic [N-1:0] r, input int p);
    int j;
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      t = r >> j;
      if (t[0]) return j;
    end
    return -1;
  endfunction

  // Bus-level invariants every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk_val("gnt_onehot", int'($countones(gnt) <= 1), 1);
      chk_val("sack_with_gnt", int'((gnt != '0) && bus_if.sack_n), 0);
      chk_val("dmr_sack_both_low", int'(!bus_if.dmr_n && !bus_if.sack_n), 0);
    end
  end

  // Request, get DMGI from the CPU, and end up with gnt asserted
  task automatic grant_up(input logic [N-1:0] req_v, input int dly, input bit busy,
                          output int w);
    int n;
    logic [N-1:0] w_oh;
    w = model_winner(req_v, rr_ptr_m);
    w_oh = '0;
    w_oh[w] = 1'b1;
    req = req_v;
    n = 0;
    while (bus_if.dmr_n !== 1'b0 && n < 8) begin tick(); n++; end
    chk_val("dmr_assert", int'(bus_if.dmr_n), 0);
    repeat (dly) tick();
    bus_if.dmgi_n = 1'b0;
    if (busy) begin
      bus_if.sync_n = 1'b0;
      bus_if.rply_n = 1'b0;
    end
    n = 0;
    do begin tick(); n++; end while (bus_if.sack_n !== 1'b0 && n < 20);
    chk_val("sack_latency", n, S + 1);
    chk_val("dmr_off_at_sack", int'(bus_if.dmr_n), 1);
    bus_if.dmgi_n = 1'b1;
    if (busy) begin
      repeat (3) begin tick(); chk_val("gnt_sync_busy", int'(gnt), 0); end
      bus_if.sync_n = 1'b1;
      repeat (3) begin tick(); chk_val("gnt_rply_busy", int'(gnt), 0); end
      bus_if.rply_n = 1'b1;
      n = 0;
      do begin tick(); n++; end while (gnt === '0 && n < 20);
      chk_val("gnt_after_idle_latency", n, S + 1);
    end else begin
      tick();
    end
    chk_val("gnt_value", int'(gnt), int'(w_oh));
    chk_val("owner_value", int'(owner), w);
  endtask

  // Hold the bus, poke non-owner done bits, then release and finish the handshake
  task automatic grant_down(input logic [N-1:0] req_v, input int w, input int hold,
                            input bit drop_rel);
    logic [N-1:0] w_oh;
    w_oh = '0;
    w_oh[w] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      done = N'($urandom) & ~w_oh;
      tick();
      chk_val("gnt_held", int'(gnt), int'(w_oh));
    end
    if (drop_rel) begin
      done = '0;
      req  = req_v & ~w_oh;
    end else begin
      done = w_oh;
    end
    tick();
    chk_val("gnt_released", int'(gnt), 0);
    chk_val("sack_in_release", int'(bus_if.sack_n), 0);
    chk_val("no_err_on_release", int'(timeout_err), 0);
    done = '0;
    tick();
    chk_val("sack_high", int'(bus_if.sack_n), 1);
    chk_val("dmr_quiet_after_release", int'(bus_if.dmr_n), 1);
    rr_ptr_m = (w + 1) % N;
  endtask

  task automatic run_txn(input logic [N-1:0] req_v, input int dly, input bit busy,
                         input int hold, input bit drop_rel);
    int w;
    grant_up(req_v, dly, busy, w);
    grant_down(req_v, w, hold, drop_rel);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    int low;
    int plen;
    int dlow;
    logic [N-1:0] rv;

    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    bus_if.dmgi_n = 1'b1;
    bus_if.sync_n = 1'b1;
    bus_if.rply_n = 1'b1;
    repeat (3) tick();
    chk_val("rst_dmr_n", int'(bus_if.dmr_n), 1);
    chk_val("rst_sack_n", int'(bus_if.sack_n), 1);
    chk_val("rst_dmgo_n", int'(bus_if.dmgo_n), 1);
    chk_val("rst_gnt", int'(gnt), 0);
    chk_val("rst_owner", int'(owner), 0);
    chk_val("rst_timeout_err", int'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Single request, CPU answers 10 cycles later, released by done
    run_txn(2'b01, 10, 1'b0, 5, 1'b0);

    // Round-robin with both requesting: owners 1, 0, 1 continue from pointer 1
    run_txn(2'b11, 2, 1'b0, 3, 1'b0);
    run_txn(2'b11, 0, 1'b0, 4, 1'b0);
    run_txn(2'b11, 5, 1'b0, 3, 1'b0);

    // Busy bus: grant waits for SYNC and RPLY both idle
    run_txn(2'b10, 3, 1'b1, 4, 1'b0);

    // Grant timeout: DMGI never arrives
    req = 2'b01;
    n = 0;
    while (bus_if.dmr_n !== 1'b0 && n < 5) begin tick(); n++; end
    low = 0;
    while (bus_if.dmr_n === 1'b0 && low < 300) begin low++; tick(); end
    chk_val("req_timeout_len", low, GTO);
    chk_val("req_timeout_err", int'(timeout_err), 1);
    req = '0;
    tick();
    chk_val("req_timeout_pulse_once", int'(timeout_err), 0);
    chk_val("req_timeout_dmr_idle", int'(bus_if.dmr_n), 1);
    tick();

    // Pass-through: nobody local wants the grant
    plen = 5;
    for (int rep = 0; rep < 2; rep++) begin
      low  = 0;
      dlow = 0;
      bus_if.dmgi_n = 1'b0;
      for (int k = 0; k < plen + 8; k++) begin
        if (k == plen) bus_if.dmgi_n = 1'b1;
        tick();
        if (bus_if.dmgo_n === 1'b0) low++;
        if (bus_if.dmr_n === 1'b0) dlow++;
      end
      chk_val("pass_dmgo_len", low, plen);
      chk_val("pass_dmr_quiet", dlow, 0);
      plen = $urandom_range(3, 12);
    end

    // Randomised transactions against the model
    for (int t = 0; t < 12; t++) begin
      rv = N'($urandom_range(1, (1 << N) - 1));
      run_txn(rv, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
              $urandom_range(1, 12), 1'($urandom_range(0, 1)));
      req = '0;
    end

    // Hold overrun: owner never lets go
    grant_up(2'b01, 4, 1'b0, w);
    n = 0;
    while (gnt !== '0 && n < MH + 20) begin n++; tick(); end
    chk_val("hold_len", n, MH);
    chk_val("hold_timeout_err", int'(timeout_err), 1);
    req = '0;
    tick();
    chk_val("hold_err_pulse_once", int'(timeout_err), 0);
    tick();
    chk_val("hold_sack_high", int'(bus_if.sack_n), 1);
    rr_ptr_m = (w + 1) % N;

    // Reset while requester 1 owns the bus, pointer last moved to 1
    run_txn(2'b01, 2, 1'b0, 2, 1'b0);
    grant_up(2'b10, 2, 1'b0, w);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_gnt", int'(gnt), 0);
    chk_val("async_rst_sack_n", int'(bus_if.sack_n), 1);
    chk_val("async_rst_dmr_n", int'(bus_if.dmr_n), 1);
    chk_val("async_rst_owner", int'(owner), 0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    rr_ptr_m = 0;
    tick();
    run_txn(2'b11, 1, 1'b0, 2, 1'b0);
    req = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
